// File: rtl/led_share_pkg.sv
// Shared types and helpers for the LED sharing scheduler.
package led_share_pkg;

    localparam int LED_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Index following idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, on the count's last value.
// No inputs besides clock/reset; tick is a decode of the registered count.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/led_share_sched.sv
// Round-robin sharing of five LEDs; grant and LEDs registered one cycle after a sampled req,
// held for HOLD_TICKS ticks then a blank gap; req is a level, never stalled. Blink: LED_SHARE_BLINK_EN.
module led_share_sched
    import led_share_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int CLK_HZ      = 12000000,
    parameter int TICK_HZ     = 1000,
    parameter int HOLD_TICKS  = 250,
    parameter int BLINK_TICKS = 50
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req,
    input  logic [LED_W*N_REQ-1:0] pat,
    output logic [N_REQ-1:0]       gnt,
    output logic                   done,
    output logic [LED_W-1:0]       leds
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PTR_W = $clog2(N_REQ);
    localparam int HC_W  = $clog2(HOLD_TICKS + 1);

    if (DIV < 2 || HOLD_TICKS < 1 || BLINK_TICKS < 1 || N_REQ < 2 || N_REQ > 8) begin : g_bad_param
        $error("led_share_sched: illegal parameter set");
    end

    logic             tick;
    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_q;
    logic [LED_W-1:0] pat_q;
    logic [HC_W-1:0]  hold_cnt;
    logic             found;
    logic [PTR_W-1:0] win;
    logic [LED_W-1:0] win_pat;

`ifdef LED_SHARE_BLINK_EN
    localparam int BC_W = $clog2(BLINK_TICKS + 1);
    logic [BC_W-1:0] blink_cnt;
    logic            blink_on;
`endif

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick)
    );

    // First requester at or after ptr, wrapping explicitly at N_REQ.
    always_comb begin
        logic [PTR_W:0] sum;
        found   = 1'b0;
        win     = '0;
        win_pat = '0;
        sum     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N_REQ)) begin
                sum = sum - (PTR_W + 1)'(N_REQ);
            end
            if (!found && req[sum[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = sum[PTR_W-1:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PTR_W'(i)) begin
                win_pat = pat[i*LED_W +: LED_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            done     <= 1'b0;
            leds     <= '0;
            ptr      <= '0;
            win_q    <= '0;
            pat_q    <= '0;
            hold_cnt <= '0;
`ifdef LED_SHARE_BLINK_EN
            blink_cnt <= '0;
            blink_on  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        pat_q    <= win_pat;
                        leds     <= win_pat;
                        gnt      <= N_REQ'(1) << win;
                        win_q    <= win;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
`ifdef LED_SHARE_BLINK_EN
                        blink_cnt <= '0;
                        blink_on  <= 1'b1;
`endif
                    end
                end
                ST_HOLD: begin
                    leds <= pat_q;
`ifdef LED_SHARE_BLINK_EN
                    if (!blink_on) begin
                        leds <= '0;
                    end
`endif
                    if (tick) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                        if (hold_cnt == HC_W'(HOLD_TICKS - 1)) begin
                            done  <= 1'b1;
                            gnt   <= '0;
                            leds  <= '0;
                            ptr   <= PTR_W'(rr_next(int'(win_q), N_REQ));
                            state <= ST_GAP;
                        end
`ifdef LED_SHARE_BLINK_EN
                        else if (blink_cnt == BC_W'(BLINK_TICKS - 1)) begin
                            blink_cnt <= '0;
                            blink_on  <= !blink_on;
                            leds      <= blink_on ? '0 : pat_q;
                        end else begin
                            blink_cnt <= blink_cnt + BC_W'(1);
                        end
`endif
                    end
                end
                ST_GAP: begin
                    leds <= '0;
                    if (tick) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/led_share_sched.md
# led_share_sched

Round-robin scheduler that shares the icestick's five user LEDs (D1..D5) among several requesters. Each requester presents a 5-bit pattern and raises a request. The block grants one requester at a time and drives its pattern for a fixed display time. A one-tick blank gap separates consecutive grants. It sits between application logic and the top-level LED pins, replacing direct LED assignment in `top`.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `CLK_HZ`, 12000000: input clock frequency.
- `TICK_HZ`, 1000: display time base; `DIV = CLK_HZ/TICK_HZ`, must be ≥2.
- `HOLD_TICKS`, 250: ticks each grant is displayed, ≥1.
- `BLINK_TICKS`, 50: half-period of blink, in ticks; used only with the blink feature.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  request per requester, level.
- `pat`  in  5*N_REQ  pattern of requester i at `pat[5i+4:5i]`; must be stable while `req[i]` is high.
- `gnt`  out  N_REQ  one-hot grant; all-zero when no grant.
- `done`  out  1  one-cycle pulse when a grant ends.
- `leds`  out  5  LED drive; bit0→D1 … bit4→D5, active-high.

## Operation
- Prescaler: counter 0..DIV-1, free-running from reset. `tick` is high for one cycle when the count equals DIV-1.
- FSM states:
  - IDLE: `leds=0`, `gnt=0`. If any `req` is high, choose the first set bit scanning from `ptr` upward with wrap. Latch that requester's pattern into `pat_q`, set `gnt` one-hot, clear the hold counter, and go to HOLD.
  - HOLD: `leds=pat_q`. Count ticks. On the tick that brings the count to HOLD_TICKS: pulse `done`, clear `gnt`, set `ptr = winner+1 mod N_REQ`, go to GAP.
  - GAP: `leds=0`. On the next `tick`, go to IDLE.
- A requester dropping `req` during HOLD does not shorten the hold.
- A requester still holding `req` after its grant is re-eligible, but at the lowest priority.
- A request withdrawn while in IDLE before it is sampled is never granted.
- `pat` changes after the latch have no effect until the next grant.
- Width rules:
  - Prescaler counter: `$clog2(DIV)` bits.
  - Hold counter: `$clog2(HOLD_TICKS+1)` bits.
  - `ptr`: `$clog2(N_REQ)` bits; the wrap is explicit, not power-of-two truncation.

## Timing
- Reset values: `gnt=0`, `done=0`, `leds=0`, `ptr=0`, state IDLE, prescaler 0.
- Reset is asynchronous: asserting `rstn` mid-HOLD blanks the LEDs and drops `gnt` immediately, with no `done` pulse.
- Grant latency: `req` high at edge k while in IDLE → `gnt` and `leds` valid after edge k (registered, 1 cycle).
- Hold duration: exactly HOLD_TICKS tick pulses after the grant edge. The wall time is (HOLD_TICKS-1)·DIV+1 to HOLD_TICKS·DIV cycles, depending on prescaler phase.
- `done` is high for the single cycle after the final tick edge; `gnt` falls on the same edge.
- GAP length: 1..DIV cycles, ending at the next tick.
- Next grant: earliest one cycle after GAP exits.
- Simultaneous requests are resolved by `ptr` only; there is no fixed priority beyond reset (requester 0 first).

## Configuration
- `LED_SHARE_BLINK_EN`:
  - Defined: during HOLD, `leds` toggles between `pat_q` and 0 every BLINK_TICKS ticks. It starts ON at grant, using a blink counter cleared at grant. HOLD length is unchanged.
  - Undefined: `leds=pat_q` steadily; the blink counter and its logic are absent.

## Structure
- Package `led_share_pkg`:
  - state encoding IDLE/HOLD/GAP;
  - `LED_W = 5`;
  - helper function for the round-robin next-index calculation.
- Sub-module `tick_gen`:
  - parameter DIV; ports `clk`, `rstn`, `tick`;
  - reused by other icestick examples.
- FSM, arbiter, pattern latch and optional blink logic stay in `led_share_sched`.

## Test plan
Bench parameters: `CLK_HZ=8`, `TICK_HZ=2` (DIV=4), `HOLD_TICKS=3`, `BLINK_TICKS=1`, `N_REQ=4`.
- Single request: `req=0001`, `pat0=10101` → `gnt=0001` and `leds=10101` one cycle later; `done` pulses after the 3rd tick; `leds=0` during GAP.
- Contention: `req=1111` held continuously → grants in order 0,1,2,3,0, each separated by a GAP with `leds=0`.
- Early withdrawal: `req2` high one cycle, then low → full 3-tick HOLD still occurs; no second grant for requester 2.
- Pattern change mid-hold: `pat1` changes from 00001 to 11111 during HOLD → `leds` stays 00001 until `done`.
- Reset mid-HOLD: `rstn=0` → `gnt=0`, `leds=0` immediately, no `done`; after release, requester 0 has priority (`ptr=0`).
- Blink (`LED_SHARE_BLINK_EN` defined): `pat0=11111` → `leds` alternates 11111/00000 each tick across the 3-tick hold; without the macro, `leds` stays 11111 throughout.
